// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// The timeout feature is enabled by defining MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef logic req_idx_t;

  localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

  // Sole requester wins; on a tie the one that was not granted last wins.
  function automatic req_idx_t pick_winner(input logic r0, input logic r1,
                                           input req_idx_t last);
    if (r0 && r1) begin
      return req_idx_t'(~last);
    end else if (r1) begin
      return req_idx_t'(1'b1);
    end else begin
      return req_idx_t'(1'b0);
    end
  endfunction

endpackage

// File: rtl/mem_arb_req_capture.sv
// Per-requester capture of a single-cycle strobe: pending flag plus latched request.
// Exposes the effective request (latched or arriving this cycle) for same-cycle arbitration.
module mem_arb_req_capture
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stb,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  block,
  input  logic                  clear,
  output logic                  req_c,
  output logic                  req_write_c,
  output logic [ADDR_WIDTH-1:0] req_addr_c,
  output logic [DATA_WIDTH-1:0] req_wdata_c
);

  logic                  pending;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept_c;

  // A strobe is dropped while a request is already held or being served.
  assign accept_c = stb & ~pending & ~block;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      pending <= (pending | accept_c) & ~clear;
      if (accept_c) begin
        write_q <= write;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  assign req_c       = pending | accept_c;
  assign req_write_c = pending ? write_q : write;
  assign req_addr_c  = pending ? addr_q  : addr;
  assign req_wdata_c = pending ? wdata_q : wdata;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one stb/ack memory port between m0 (CPU) and m1 (loader).
// Defining MEM_ARB_TIMEOUT_EN adds a WAIT watchdog, TIMEOUT_CYCLES and the sticky err_o.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 15
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_stb_i,
  input  logic                  m0_write_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_ack_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_stb_i,
  input  logic                  m1_write_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_ack_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  mem_stb_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o,
  output logic                  grant_o
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic                  err_o
`endif
);

  arb_state_t state;
  req_idx_t   last_grant;

  logic                  req0_c, req1_c;
  logic                  write0_c, write1_c;
  logic [ADDR_WIDTH-1:0] addr0_c, addr1_c;
  logic [DATA_WIDTH-1:0] wdata0_c, wdata1_c;

  logic                  active_c;
  logic                  timeout_c;
  logic                  done_c;
  logic                  any_req_c;
  req_idx_t              win_c;
  logic                  win_write_c;
  logic [ADDR_WIDTH-1:0] win_addr_c;
  logic [DATA_WIDTH-1:0] win_wdata_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic                  block0_c, block1_c;
  logic                  clear0_c, clear1_c;

  assign active_c = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle that still has no memory ack.
  assign timeout_c = (state == WAIT) && !mem_ack_i &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + CNT_W'(1) : '0;
      if (timeout_c) begin
        err_o <= 1'b1;
      end
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  assign done_c  = active_c & (mem_ack_i | timeout_c);
  assign rdata_c = timeout_c ? DATA_WIDTH'(TIMEOUT_RDATA) : mem_rdata_i;

  assign m0_ack_o   = done_c & (grant_o == 1'b0);
  assign m1_ack_o   = done_c & (grant_o == 1'b1);
  assign m0_rdata_o = (active_c && grant_o == 1'b0) ? rdata_c : '0;
  assign m1_rdata_o = (active_c && grant_o == 1'b1) ? rdata_c : '0;

  // The owner may queue its next request in the cycle it receives its ack.
  assign block0_c = active_c & (grant_o == 1'b0) & ~m0_ack_o;
  assign block1_c = active_c & (grant_o == 1'b1) & ~m1_ack_o;

  assign any_req_c   = req0_c | req1_c;
  assign win_c       = pick_winner(req0_c, req1_c, last_grant);
  assign win_write_c = win_c ? write1_c : write0_c;
  assign win_addr_c  = win_c ? addr1_c  : addr0_c;
  assign win_wdata_c = win_c ? wdata1_c : wdata0_c;

  assign clear0_c = (state == IDLE) & any_req_c & (win_c == 1'b0);
  assign clear1_c = (state == IDLE) & any_req_c & (win_c == 1'b1);

  mem_arb_req_capture #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cap0 (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .stb        (m0_stb_i),
    .write      (m0_write_i),
    .addr       (m0_addr_i),
    .wdata      (m0_wdata_i),
    .block      (block0_c),
    .clear      (clear0_c),
    .req_c      (req0_c),
    .req_write_c(write0_c),
    .req_addr_c (addr0_c),
    .req_wdata_c(wdata0_c)
  );

  mem_arb_req_capture #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cap1 (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .stb        (m1_stb_i),
    .write      (m1_write_i),
    .addr       (m1_addr_i),
    .wdata      (m1_wdata_i),
    .block      (block1_c),
    .clear      (clear1_c),
    .req_c      (req1_c),
    .req_write_c(write1_c),
    .req_addr_c (addr1_c),
    .req_wdata_c(wdata1_c)
  );

  // Arbitration and memory-side sequencing; request fields are held from ISSUE through WAIT.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      last_grant  <= req_idx_t'(1'b1);
      grant_o     <= 1'b0;
      busy_o      <= 1'b0;
      mem_stb_o   <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req_c) begin
            state       <= ISSUE;
            busy_o      <= 1'b1;
            grant_o     <= win_c;
            last_grant  <= win_c;
            mem_stb_o   <= 1'b1;
            mem_write_o <= win_write_c;
            mem_addr_o  <= win_addr_c;
            mem_wdata_o <= win_wdata_c;
          end
        end
        ISSUE: begin
          mem_stb_o <= 1'b0;
          if (mem_ack_i) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack_i || timeout_c) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          busy_o      <= 1'b0;
          mem_stb_o   <= 1'b0;
          mem_write_o <= 1'b0;
          mem_addr_o  <= '0;
          mem_wdata_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs change 1ns after posedge, checks 2ns later.
// The timeout scenario runs only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_stb, m0_write, m1_stb, m1_write;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_stb, mem_write, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, grant;
`ifdef MEM_ARB_TIMEOUT_EN
  logic          err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .m0_stb_i   (m0_stb),
    .m0_write_i (m0_write),
    .m0_addr_i  (m0_addr),
    .m0_wdata_i (m0_wdata),
    .m0_ack_o   (m0_ack),
    .m0_rdata_o (m0_rdata),
    .m1_stb_i   (m1_stb),
    .m1_write_i (m1_write),
    .m1_addr_i  (m1_addr),
    .m1_wdata_i (m1_wdata),
    .m1_ack_o   (m1_ack),
    .m1_rdata_o (m1_rdata),
    .mem_stb_o  (mem_stb),
    .mem_write_o(mem_write),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_ack_i  (mem_ack),
    .mem_rdata_i(mem_rdata),
    .busy_o     (busy),
    .grant_o    (grant)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .err_o      (err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and return strobes/ack to their idle values.
  task automatic tick();
    @(posedge clk);
    #1;
    m0_stb    = 1'b0;
    m1_stb    = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 8'hEE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    m0_stb = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_stb = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0;
    mem_ack = 1'b0; mem_rdata = 8'h77;

    // Reset state; a memory ack during reset reaches nobody.
    tick(); tick();
    mem_ack = 1'b1;
    #2;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_mem_stb", 32'(mem_stb), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_m0_ack", 32'(m0_ack), 32'h0);
    check("rst_m1_rdata", 32'(m1_rdata), 32'h0);
    rst_n = 1'b1;

    // Simultaneous strobes from reset: m0 first (zero-wait), m1 two cycles later.
    tick();
    m0_stb = 1'b1; m0_write = 1'b1; m0_addr = 6'h11; m0_wdata = 8'h5A;
    m1_stb = 1'b1; m1_write = 1'b0; m1_addr = 6'h22; m1_wdata = 8'h00;
    #2 check("a_idle_stb", 32'(mem_stb), 32'h0);
    tick();
    mem_ack = 1'b1;
    #2;
    check("a0_stb", 32'(mem_stb), 32'h1);
    check("a0_write", 32'(mem_write), 32'h1);
    check("a0_addr", 32'(mem_addr), 32'h11);
    check("a0_wdata", 32'(mem_wdata), 32'h5A);
    check("a0_grant", 32'(grant), 32'h0);
    check("a0_m0_ack", 32'(m0_ack), 32'h1);
    check("a0_m1_ack", 32'(m1_ack), 32'h0);
    tick();
    #2;
    check("a_gap_busy", 32'(busy), 32'h0);
    check("a_gap_stb", 32'(mem_stb), 32'h0);
    check("a_gap_addr", 32'(mem_addr), 32'h0);
    tick();
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    #2;
    check("a1_stb", 32'(mem_stb), 32'h1);
    check("a1_addr", 32'(mem_addr), 32'h22);
    check("a1_write", 32'(mem_write), 32'h0);
    check("a1_grant", 32'(grant), 32'h1);
    check("a1_m1_ack", 32'(m1_ack), 32'h1);
    check("a1_m1_rdata", 32'(m1_rdata), 32'hC3);
    check("a1_m0_ack", 32'(m0_ack), 32'h0);
    check("a1_m0_rdata", 32'(m0_rdata), 32'h0);

    // m0 read of 0x05 alone, memory acks two cycles after mem_stb.
    tick();
    m0_stb = 1'b1; m0_write = 1'b0; m0_addr = 6'h05;
    #2 check("b_t_stb", 32'(mem_stb), 32'h0);
    tick();
    #2;
    check("b_t1_stb", 32'(mem_stb), 32'h1);
    check("b_t1_addr", 32'(mem_addr), 32'h05);
    check("b_t1_busy", 32'(busy), 32'h1);
    check("b_t1_grant", 32'(grant), 32'h0);
    tick();
    #2;
    check("b_wait_stb", 32'(mem_stb), 32'h0);
    check("b_wait_addr", 32'(mem_addr), 32'h05);
    check("b_wait_ack", 32'(m0_ack), 32'h0);
    tick();
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    #2;
    check("b_m0_ack", 32'(m0_ack), 32'h1);
    check("b_m0_rdata", 32'(m0_rdata), 32'hA5);
    check("b_m1_ack", 32'(m1_ack), 32'h0);
    check("b_m1_rdata", 32'(m1_rdata), 32'h0);
    tick();
    #2 check("b_done_busy", 32'(busy), 32'h0);

    // Same simultaneous pattern after m0 was last served: m1 goes first.
    m0_stb = 1'b1; m0_write = 1'b1; m0_addr = 6'h01; m0_wdata = 8'h44;
    m1_stb = 1'b1; m1_write = 1'b0; m1_addr = 6'h02;
    tick();
    mem_ack = 1'b1; mem_rdata = 8'h5C;
    #2;
    check("c0_grant", 32'(grant), 32'h1);
    check("c0_addr", 32'(mem_addr), 32'h02);
    check("c0_m1_ack", 32'(m1_ack), 32'h1);
    check("c0_m1_rdata", 32'(m1_rdata), 32'h5C);
    check("c0_m0_ack", 32'(m0_ack), 32'h0);
    tick();
    tick();
    mem_ack = 1'b1;
    #2;
    check("c1_grant", 32'(grant), 32'h0);
    check("c1_addr", 32'(mem_addr), 32'h01);
    check("c1_wdata", 32'(mem_wdata), 32'h44);
    check("c1_m0_ack", 32'(m0_ack), 32'h1);

    // m1 write queued during m0 WAIT; m0 duplicate ignored, strobe with own ack kept.
    tick();
    m0_stb = 1'b1; m0_write = 1'b0; m0_addr = 6'h0A;
    tick();
    #2 check("d_issue_addr", 32'(mem_addr), 32'h0A);
    tick();
    m1_stb = 1'b1; m1_write = 1'b1; m1_addr = 6'h3F; m1_wdata = 8'h3C;
    m0_stb = 1'b1; m0_addr = 6'h15;
    #2;
    check("d_wait_addr", 32'(mem_addr), 32'h0A);
    check("d_wait_m1_ack", 32'(m1_ack), 32'h0);
    tick();
    mem_ack = 1'b1; mem_rdata = 8'h11;
    m0_stb = 1'b1; m0_addr = 6'h2B;
    #2;
    check("d_m0_ack", 32'(m0_ack), 32'h1);
    check("d_m0_rdata", 32'(m0_rdata), 32'h11);
    tick();
    #2;
    check("d_gap_busy", 32'(busy), 32'h0);
    check("d_gap_stb", 32'(mem_stb), 32'h0);
    tick();
    mem_ack = 1'b1;
    #2;
    check("d_m1_stb", 32'(mem_stb), 32'h1);
    check("d_m1_write", 32'(mem_write), 32'h1);
    check("d_m1_addr", 32'(mem_addr), 32'h3F);
    check("d_m1_wdata", 32'(mem_wdata), 32'h3C);
    check("d_m1_grant", 32'(grant), 32'h1);
    check("d_m1_ack", 32'(m1_ack), 32'h1);
    tick();
    tick();
    mem_ack = 1'b1;
    #2;
    check("d_req_stb", 32'(mem_stb), 32'h1);
    check("d_req_addr", 32'(mem_addr), 32'h2B);
    check("d_req_grant", 32'(grant), 32'h0);
    check("d_req_ack", 32'(m0_ack), 32'h1);
    tick();
    tick();
    #2 check("d_no_dup_busy", 32'(busy), 32'h0);

    // Reset for one cycle during WAIT with m1 pending; late ack is ignored.
    tick();
    m0_stb = 1'b1; m0_write = 1'b0; m0_addr = 6'h07;
    tick();
    tick();
    m1_stb = 1'b1; m1_write = 1'b1; m1_addr = 6'h30; m1_wdata = 8'h09;
    #2 check("e_wait_busy", 32'(busy), 32'h1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 8'h99;
    #2;
    check("e_m0_ack", 32'(m0_ack), 32'h0);
    check("e_m1_ack", 32'(m1_ack), 32'h0);
    check("e_busy", 32'(busy), 32'h0);
    check("e_addr", 32'(mem_addr), 32'h0);
    check("e_write", 32'(mem_write), 32'h0);
    check("e_grant", 32'(grant), 32'h0);
    check("e_m0_rdata", 32'(m0_rdata), 32'h0);
    tick();
    #2;
    check("e_after_busy", 32'(busy), 32'h0);
    check("e_after_stb", 32'(mem_stb), 32'h0);
    tick();
    #2 check("e_after2_stb", 32'(mem_stb), 32'h0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never acks: forced completion on the 15th WAIT cycle.
    tick();
    m0_stb = 1'b1; m0_write = 1'b0; m0_addr = 6'h03;
    tick();
    for (int i = 2; i <= 15; i++) tick();
    #2;
    check("t_early_ack", 32'(m0_ack), 32'h0);
    check("t_early_err", 32'(err), 32'h0);
    tick();
    #2;
    check("t_ack", 32'(m0_ack), 32'h1);
    check("t_rdata", 32'(m0_rdata), 32'hFF);
    check("t_m1_ack", 32'(m1_ack), 32'h0);
    tick();
    #2;
    check("t_busy", 32'(busy), 32'h0);
    check("t_err", 32'(err), 32'h1);
    tick();
    tick();
    #2 check("t_err_sticky", 32'(err), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
